aes_inv_cipher_top: RTL and testbench

Iterative AES-128 decryption core, the receive-side counterpart of the existing AES-128 encryption core. It expands a loaded 128-bit key into the 11 round keys and stores them. It then decrypts 128-bit ciphertext blocks at one round per clock. It sits beside the encryption core and uses the same `ld`/`done` handshake and byte ordering, with byte 0 at bits [127:120].

---
 rtl/aes_inv_cipher_pkg.sv | 103 ++++++++++
 rtl/aes_inv_sbox.sv | 12 +
 rtl/aes_sbox.sv | 12 +
 rtl/aes_inv_cipher_top.sv | 134 +++++++++++++
 tb/tb_aes_inv_cipher_top.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_inv_cipher_pkg.sv
// Shared AES-128 constants, FSM encoding and GF(2^8) helpers for the inverse cipher.
// Holds the Rcon table, xtime, the multiply-by-{09,0b,0d,0e} helpers and InvShiftRows/InvMixColumns.
package aes_inv_cipher_pkg;

    localparam int AES_NR = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KEXP = 2'd1,
        DEC  = 2'd2
    } state_t;

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = a;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) r = gf_mul(r, sq);
            sq = gf_mul(sq, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] mul_09(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] mul_0b(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] mul_0d(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] mul_0e(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {mul_0e(a0) ^ mul_0b(a1) ^ mul_0d(a2) ^ mul_09(a3),
                mul_09(a0) ^ mul_0e(a1) ^ mul_0b(a2) ^ mul_0d(a3),
                mul_0d(a0) ^ mul_09(a1) ^ mul_0e(a2) ^ mul_0b(a3),
                mul_0b(a0) ^ mul_0d(a1) ^ mul_09(a2) ^ mul_0e(a3)};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
        return o;
    endfunction

    // Byte (row r, column c) sits at index r+4c; row r rotates right by r columns.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Inverse AES S-box: inverse affine map followed by the GF(2^8) inverse.
module aes_inv_sbox
    import aes_inv_cipher_pkg::*;
(
    input  logic [7:0] x,
    output logic [7:0] y
);
    logic [7:0] t;

    assign t = rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05;
    assign y = gf_inv(t);
endmodule

// File: rtl/aes_sbox.sv
// Forward AES S-box: GF(2^8) inverse followed by the FIPS-197 affine map.
module aes_sbox
    import aes_inv_cipher_pkg::*;
(
    input  logic [7:0] x,
    output logic [7:0] y
);
    logic [7:0] b;

    assign b = gf_inv(x);
    assign y = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
endmodule

// File: rtl/aes_inv_cipher_top.sv
// Iterative AES-128 decryption: stores 11 expanded round keys, then one inverse round per clock.
//   state | meaning
//   IDLE  | waiting for kld (expand key) or ld (decrypt, needs kdone)
//   KEXP  | writing rk[1..10], one per edge
//   DEC   | inverse rounds 9..1, final round writes text_out
module aes_inv_cipher_top
    import aes_inv_cipher_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         kld,
    output logic         kdone,
    input  logic [127:0] key,
    input  logic         ld,
    input  logic [127:0] text_in,
    output logic         done,
    output logic         busy,
    output logic [127:0] text_out
);
    localparam logic [3:0] LAST_RND = 4'(AES_NR);

    state_t       state, next_state;
    logic [3:0]   rnd;
    logic [127:0] rk [0:AES_NR];
    logic [127:0] kexp_prev, next_rk;
    logic [127:0] blk, isr, isb, ark;
    logic [31:0]  rot_w3, rot_sub, kx_temp;
    logic [31:0]  n0, n1, n2, n3;
    logic         key_start, key_step, dec_start, dec_step;

    // Key expansion works from the most recently written round key.
    assign rot_w3 = {kexp_prev[23:0], kexp_prev[31:24]};

    for (genvar j = 0; j < 4; j++) begin : g_sbox
        aes_sbox u_sbox (.x(rot_w3[31-8*j -: 8]), .y(rot_sub[31-8*j -: 8]));
    end

    assign kx_temp = rot_sub ^ {rcon(rnd), 24'h000000};
    assign n0      = kexp_prev[127:96] ^ kx_temp;
    assign n1      = kexp_prev[95:64]  ^ n0;
    assign n2      = kexp_prev[63:32]  ^ n1;
    assign n3      = kexp_prev[31:0]   ^ n2;
    assign next_rk = {n0, n1, n2, n3};

    assign isr = inv_shift_rows(blk);

    for (genvar i = 0; i < 16; i++) begin : g_inv_sbox
        aes_inv_sbox u_inv_sbox (.x(isr[127-8*i -: 8]), .y(isb[127-8*i -: 8]));
    end

    assign ark = isb ^ rk[rnd];

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (kld)               next_state = KEXP;
                else if (ld && kdone)  next_state = DEC;
            end
            KEXP:    if (rnd == LAST_RND) next_state = IDLE;
            DEC:     if (rnd == 4'd0)     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        key_start = 1'b0;
        key_step  = 1'b0;
        dec_start = 1'b0;
        dec_step  = 1'b0;
        case (state)
            IDLE: begin
                if (kld)               key_start = 1'b1;
                else if (ld && kdone)  dec_start = 1'b1;
            end
            KEXP:    key_step = 1'b1;
            DEC:     dec_step = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rnd      <= 4'd0;
            kdone    <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
            text_out <= '0;
        end else begin
            done <= 1'b0;
            busy <= (next_state != IDLE);
            if (key_start) begin
                rnd   <= 4'd1;
                kdone <= 1'b0;
            end else if (key_step) begin
                if (rnd == LAST_RND) begin
                    rnd   <= 4'd0;
                    kdone <= 1'b1;
                end else begin
                    rnd <= rnd + 4'd1;
                end
            end else if (dec_start) begin
                rnd <= LAST_RND - 4'd1;
            end else if (dec_step) begin
                if (rnd == 4'd0) begin
                    text_out <= ark;
                    done     <= 1'b1;
                end else begin
                    rnd <= rnd - 4'd1;
                end
            end
        end
    end

    // Key store and round state carry no reset: kdone=0 keeps them unused until rewritten.
    always_ff @(posedge clk) begin
        if (key_start) begin
            rk[0]     <= key;
            kexp_prev <= key;
        end
        if (key_step) begin
            rk[rnd]   <= next_rk;
            kexp_prev <= next_rk;
        end
        if (dec_start) blk <= text_in ^ rk[AES_NR];
        if (dec_step)  blk <= inv_mix_columns(ark);
    end

endmodule

// File: tb/tb_aes_inv_cipher_top.sv
// Bench for aes_inv_cipher_top: FIPS-197 vectors plus random blocks encrypted by a forward-AES model.
module tb_aes_inv_cipher_top;

    logic         clk = 1'b0;
    logic         reset;
    logic         kld;
    logic         kdone;
    logic [127:0] key;
    logic         ld;
    logic [127:0] text_in;
    logic         done;
    logic         busy;
    logic [127:0] text_out;

    int n_tests   = 0;
    int n_fail    = 0;
    int done_seen = 0;

    logic [7:0] sbox_tab [0:255];

    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] RT_KEY = 128'hcafebabedeadbeefdeadbeef00000000;
    localparam logic [127:0] RT_PT  = 128'hE5E9186FA729469697547738A3E2ABF5;

    aes_inv_cipher_top dut (
        .clk      (clk),
        .reset    (reset),
        .kld      (kld),
        .kdone    (kdone),
        .key      (key),
        .ld       (ld),
        .text_in  (text_in),
        .done     (done),
        .busy     (busy),
        .text_out (text_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // S-box table generated by walking the multiplicative group with generator 3.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_tab[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_tab[0] = 8'h63;
    endtask

    function automatic logic [127:0] encrypt(input logic [127:0] k, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox_tab[tmp[23:16]], sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]],
                       sbox_tab[tmp[31:24]]} ^ {rc, 24'h000000};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int j = 0; j < 16; j++) s[j] = pt[127-8*j -: 8] ^ w[j/4][31-8*(j%4) -: 8];
        for (int r_i = 1; r_i <= 10; r_i++) begin
            for (int j = 0; j < 16; j++) t[j] = sbox_tab[s[j]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[r+4*c] = t[r+4*((c+r)%4)];
            if (r_i < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int j = 0; j < 16; j++) s[j] = s[j] ^ w[4*r_i + j/4][31-8*(j%4) -: 8];
        end
        for (int j = 0; j < 16; j++) res[127-8*j -: 8] = s[j];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (done === 1'b1) done_seen++;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_key(input logic [127:0] k, input bit early_ld);
        int cnt;
        kld = 1'b1;
        key = k;
        tick();
        kld = 1'b0;
        check("kexp_start", 128'({busy, kdone}), 128'(2'b10));
        cnt = 0;
        while (kdone !== 1'b1 && cnt < 20) begin
            if (early_ld && cnt == 3) begin
                ld      = 1'b1;
                text_in = rand128();
            end else begin
                ld = 1'b0;
            end
            tick();
            cnt++;
        end
        ld = 1'b0;
        check("kexp_latency", 128'(cnt), 128'(10));
        check("kexp_busy_end", 128'(busy), 128'(0));
    endtask

    task automatic decrypt(input logic [127:0] ct, input logic [127:0] pt, input string tag, input bit mid);
        int cnt;
        int d0;
        d0      = done_seen;
        ld      = 1'b1;
        text_in = ct;
        tick();
        ld = 1'b0;
        check({tag, "_busy"}, 128'(busy), 128'(1));
        cnt = 0;
        while (done !== 1'b1 && cnt < 30) begin
            if (mid && cnt == 3) begin
                ld      = 1'b1;
                text_in = ~ct;
            end else begin
                ld = 1'b0;
            end
            tick();
            cnt++;
        end
        ld = 1'b0;
        check({tag, "_latency"}, 128'(cnt), 128'(10));
        check({tag, "_text"}, text_out, pt);
        check({tag, "_busy_end"}, 128'(busy), 128'(0));
        repeat (mid ? 14 : 1) tick();
        check({tag, "_ndone"}, 128'(done_seen - d0), 128'(1));
        check({tag, "_held"}, text_out, pt);
    endtask

    initial begin
        logic [127:0] k, p, c;
        int d0, cnt;
        reset   = 1'b0;
        kld     = 1'b0;
        ld      = 1'b0;
        key     = '0;
        text_in = '0;
        build_sbox();
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("reset_flags", 128'({kdone, done, busy}), 128'(0));
        check("reset_text", text_out, 128'(0));

        // ld with no key expanded
        d0      = done_seen;
        ld      = 1'b1;
        text_in = C1_CT;
        tick();
        ld = 1'b0;
        repeat (14) tick();
        check("early_ld_ndone", 128'(done_seen - d0), 128'(0));
        check("early_ld_text", text_out, 128'(0));
        check("early_ld_busy", 128'(busy), 128'(0));

        // ld during KEXP
        d0 = done_seen;
        load_key(C1_KEY, 1'b1);
        repeat (12) tick();
        check("kexp_ld_ndone", 128'(done_seen - d0), 128'(0));
        check("kexp_ld_text", text_out, 128'(0));

        decrypt(C1_CT, C1_PT, "fips_c1", 1'b1);

        load_key(B_KEY, 1'b0);
        decrypt(B_CT, B_PT, "fips_b", 1'b0);
        for (int i = 0; i < 2; i++) begin
            p = rand128();
            decrypt(encrypt(B_KEY, p), p, "keep_key", 1'b0);
        end

        // kld and ld together in IDLE: key reload wins
        k       = rand128();
        d0      = done_seen;
        kld     = 1'b1;
        key     = k;
        ld      = 1'b1;
        text_in = B_CT;
        tick();
        kld = 1'b0;
        ld  = 1'b0;
        check("both_kdone", 128'({busy, kdone}), 128'(2'b10));
        cnt = 0;
        while (kdone !== 1'b1 && cnt < 20) begin
            tick();
            cnt++;
        end
        check("both_kexp_latency", 128'(cnt), 128'(10));
        check("both_ndone", 128'(done_seen - d0), 128'(0));
        p = rand128();
        decrypt(encrypt(k, p), p, "both_dec", 1'b0);

        for (int i = 0; i < 3; i++) begin
            k = rand128();
            load_key(k, 1'b0);
            for (int j = 0; j < 2; j++) begin
                p = rand128();
                decrypt(encrypt(k, p), p, "rand", 1'b0);
            end
        end

        c = encrypt(RT_KEY, RT_PT);
        load_key(RT_KEY, 1'b0);
        decrypt(c, RT_PT, "round_trip", 1'b0);

        // reset at cycle 5 of a decryption
        d0      = done_seen;
        ld      = 1'b1;
        text_in = c;
        tick();
        ld = 1'b0;
        repeat (4) tick();
        reset = 1'b0;
        tick();
        check("rst_flags", 128'({kdone, done, busy}), 128'(0));
        check("rst_text", text_out, 128'(0));
        reset = 1'b1;
        repeat (12) tick();
        check("rst_ndone", 128'(done_seen - d0), 128'(0));
        check("rst_kdone", 128'(kdone), 128'(0));
        ld      = 1'b1;
        text_in = c;
        tick();
        ld = 1'b0;
        repeat (14) tick();
        check("rst_ld_ndone", 128'(done_seen - d0), 128'(0));
        check("rst_ld_text", text_out, 128'(0));
        check("rst_ld_busy", 128'(busy), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
